alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
Shares one `alu` instance between NUM_REQ independent requesters, for example the integer pipe and a microcoded CSR/trap sequencer. Requests arrive on per-requester valid/ready channels and are granted round-robin. The ALU result is registered and returned on the owning requester's response channel, with full backpressure. The block also keeps a wrapping count of completed operations for performance counters.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
CNT_W, 16, width of completed-operation counter

Ports:
clk  input  1  core clock
reset_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  request present, one bit per requester
req_ready  output  NUM_REQ  request accepted this cycle (one-hot or zero)
req_in1  input  NUM_REQ*32  operand 1, requester i at [32*i+:32]
req_in2  input  NUM_REQ*32  operand 2, same packing
req_cmd  input  NUM_REQ*3  alu_cmd encoding, requester i at [3*i+:3]
resp_valid  output  NUM_REQ  result valid for requester i (one-hot or zero)
resp_ready  input  NUM_REQ  requester i consumes result
resp_data  output  32  registered ALU result, shared by all requesters
ops_done  output  CNT_W  completed (handshaken) responses, wraps
busy  output  1  result buffer occupied

Behaviour:
- Clock and reset: single clock; asynchronous active-low reset reset_n.
- Reset values: resp_valid=0, resp_data=0, ops_done=0, busy=0. Round-robin pointer last_grant=NUM_REQ-1, so requester 0 has top priority after reset.
- req_ready is combinational. It is only ever set for the granted requester.
- States:
  - EMPTY: no result buffered.
  - FULL: result buffered; owner index held in owner.
- Accept condition: can_accept = (state==EMPTY) || (resp_ready[owner]), i.e. a same-cycle drain-and-refill is allowed, giving one op per cycle throughput.
- Grant:
  - If can_accept and any req_valid, grant the first valid requester scanning last_grant+1, last_grant+2, … modulo NUM_REQ.
  - req_ready[grant]=1; all other bits 0.
  - last_grant updates to grant only on accept.
  - A requester that is not granted keeps its valid asserted. Its operands must stay stable, and the block never drops it.
- Datapath:
  - The granted requester's in1/in2/cmd are muxed into the `alu` instance. should_glitch, if present under MITSHD_LAB6, is tied to 0.
  - alu_out is captured into resp_data on accept. Latency is 1 cycle from the req handshake to resp_valid.
- Transitions:
  - EMPTY + accept → FULL, owner=grant.
  - FULL + resp_ready[owner] + accept → FULL, new owner, new data.
  - FULL + resp_ready[owner], no request → EMPTY.
  - FULL, no resp_ready[owner] → hold. resp_data and owner must not change.
- resp_valid[i] = (state==FULL) && (owner==i).
- busy = (state==FULL).
- resp_ready on a non-owner bit is ignored.
- ops_done increments by 1 on each resp handshake and wraps from 2^CNT_W−1 to 0.
- req_cmd values outside alu_cmd are impossible (3-bit full decode). All 8 encodings pass through.
- Simultaneous requests from all requesters: exactly one is granted per accept cycle. Worst-case wait is NUM_REQ−1 grants.
- Reset asserted mid-operation: the buffered result is discarded immediately (async) and is not retried. Requesters must reissue.
- No combinational path from resp_ready to resp_data. A path from resp_ready to req_ready is allowed (via can_accept).

Decomposition:
- Shared package (defines.sv): reuse alu_cmd; add ALU_ARB_MAX_REQ=4 and an arb_state_t enum {ARB_EMPTY, ARB_FULL}.
- Sub-module rr_picker (NUM_REQ): combinational round-robin picker from valid vector + last_grant → grant index + any_valid. It is reusable for the memory port arbiter.

Test Plan:
- Reset, then req0 valid in1=0x500 in2=0x100 cmd=add, resp_ready0=1 → req_ready0 in cycle 0; next cycle resp_valid=0b01, resp_data=0x600; ops_done=1.
- req0 and req1 valid every cycle, resp_ready=all 1, req0=sub(10,3), req1=xor(0xF0,0xFF) → grants alternate 0,1,0,1; responses alternate 7 and 0x0F; one per cycle; ops_done=4 after 4 cycles.
- req1 sll(1,31) accepted, resp_ready1=0 for 5 cycles while req0 valid → resp_data held 0x80000000, req_ready0=0 throughout; when resp_ready1=1, req0 is granted the same cycle.
- Back-to-back sra(0x80000000,4) then srl(0x80000000,4) from req0 → 0xF8000000 then 0x08000000 on consecutive cycles.
- Assert reset_n=0 while FULL with resp_data=0x1234 → resp_valid, busy and resp_data go to 0 without waiting for a clock edge; after release, requester 0 wins a simultaneous 0/1 request.
- Preload ops_done to 0xFFFF (CNT_W=16) via 65535 handshakes or a force, then one handshake → ops_done=0.

Source files
------------

// File: rtl/alu_share_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter_pkg
// Shared types and constants for the shared-ALU arbiter and its helpers.
//   alu_cmd_e     : 3-bit ALU command, all eight encodings are legal
//   arb_state_t   : result-buffer state (EMPTY / FULL)
//   ALU_ARB_MAX_REQ, ARB_IDX_W : requester limit and index width
// ---------------------------------------------------------------------------
package alu_share_arbiter_pkg;

   localparam int ALU_ARB_MAX_REQ = 4;
   localparam int ARB_IDX_W       = 2;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4,
      ALU_SLL = 3'd5,
      ALU_SRL = 3'd6,
      ALU_SRA = 3'd7
   } alu_cmd_e;

   typedef enum logic {
      ARB_EMPTY = 1'b0,
      ARB_FULL  = 1'b1
   } arb_state_t;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// ---------------------------------------------------------------------------
// alu
// Purely combinational 32-bit integer ALU.
//   in1_i, in2_i : operands (shift amount is in2_i[4:0])
//   cmd_i        : operation select
//   alu_out_o    : result
// ---------------------------------------------------------------------------
module alu
   import alu_share_arbiter_pkg::*;
(
   input  logic [31:0] in1_i,
   input  logic [31:0] in2_i,
   input  alu_cmd_e    cmd_i,
   output logic [31:0] alu_out_o
);

   always_comb begin
      alu_out_o = '0;
      case (cmd_i)
         ALU_ADD: alu_out_o = in1_i + in2_i;
         ALU_SUB: alu_out_o = in1_i - in2_i;
         ALU_AND: alu_out_o = in1_i & in2_i;
         ALU_OR:  alu_out_o = in1_i | in2_i;
         ALU_XOR: alu_out_o = in1_i ^ in2_i;
         ALU_SLL: alu_out_o = in1_i << in2_i[4:0];
         ALU_SRL: alu_out_o = in1_i >> in2_i[4:0];
         ALU_SRA: alu_out_o = $unsigned($signed(in1_i) >>> in2_i[4:0]);
         default: alu_out_o = '0;
      endcase
   end

endmodule

// File: rtl/alu_share_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter_rr_picker
// Combinational round-robin picker. Scans last_grant+1, last_grant+2, ...
// modulo NUM_REQ and returns the first valid index.
//   valid_i      : request vector
//   last_grant_i : index granted most recently
//   grant_o      : chosen index (meaningful only when any_valid_o)
//   any_valid_o  : at least one request present
// ---------------------------------------------------------------------------
module alu_share_arbiter_rr_picker
   import alu_share_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2
)
(
   input  logic [NUM_REQ-1:0]   valid_i,
   input  logic [ARB_IDX_W-1:0] last_grant_i,
   output logic [ARB_IDX_W-1:0] grant_o,
   output logic                 any_valid_o
);

   // Padded to the maximum width so a 2-bit index never overruns the vector.
   logic [ALU_ARB_MAX_REQ-1:0] valid_pad;
   logic [ARB_IDX_W-1:0]       cand [NUM_REQ];

   genvar gi;
   for (gi = 0; gi < ALU_ARB_MAX_REQ; gi++) begin : g_pad
      if (gi < NUM_REQ) begin : g_real
         assign valid_pad[gi] = valid_i[gi];
      end else begin : g_zero
         assign valid_pad[gi] = 1'b0;
      end
   end

   // cand[d] is the requester at round-robin distance d+1 from last_grant.
   for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign cand[gi] = ARB_IDX_W'((int'(last_grant_i) + gi + 1) % NUM_REQ);
   end

   // Walk from the farthest candidate to the nearest so the nearest valid
   // one is the last to write, i.e. wins.
   always_comb begin
      grant_o     = last_grant_i;
      any_valid_o = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (valid_pad[cand[k]]) begin
            grant_o     = cand[k];
            any_valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
// Shares one ALU between NUM_REQ requesters with round-robin arbitration and
// a one-entry registered result buffer with full backpressure.
//   clk, reset_n           : clock, asynchronous active-low reset
//   req_valid / req_ready  : per-requester request handshake
//   req_in1, req_in2       : packed 32-bit operands, requester i at [32*i+:32]
//   req_cmd                : packed 3-bit command, requester i at [3*i+:3]
//   resp_valid / resp_ready: per-requester response handshake (one-hot)
//   resp_data              : registered ALU result, shared by all requesters
//   ops_done               : wrapping count of response handshakes
//   busy                   : result buffer occupied
// ---------------------------------------------------------------------------
module alu_share_arbiter
   import alu_share_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int CNT_W   = 16
)
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [NUM_REQ*32-1:0] req_in1,
   input  logic [NUM_REQ*32-1:0] req_in2,
   input  logic [NUM_REQ*3-1:0]  req_cmd,
   output logic [NUM_REQ-1:0]    resp_valid,
   input  logic [NUM_REQ-1:0]    resp_ready,
   output logic [31:0]           resp_data,
   output logic [CNT_W-1:0]      ops_done,
   output logic                  busy
);

   arb_state_t           state_q, state_d;
   logic [ARB_IDX_W-1:0] owner_q, owner_d;
   logic [ARB_IDX_W-1:0] last_grant_q, last_grant_d;
   logic [31:0]          resp_data_q, resp_data_d;
   logic [CNT_W-1:0]     ops_done_q, ops_done_d;

   // Requester-side views padded to the maximum count so the 2-bit
   // owner/grant indices can select directly.
   logic [31:0]                in1_arr [ALU_ARB_MAX_REQ];
   logic [31:0]                in2_arr [ALU_ARB_MAX_REQ];
   logic [2:0]                 cmd_arr [ALU_ARB_MAX_REQ];
   logic [ALU_ARB_MAX_REQ-1:0] resp_ready_pad;

   genvar gi;
   for (gi = 0; gi < ALU_ARB_MAX_REQ; gi++) begin : g_unpack
      if (gi < NUM_REQ) begin : g_real
         assign in1_arr[gi]        = req_in1[32*gi +: 32];
         assign in2_arr[gi]        = req_in2[32*gi +: 32];
         assign cmd_arr[gi]        = req_cmd[3*gi +: 3];
         assign resp_ready_pad[gi] = resp_ready[gi];
      end else begin : g_zero
         assign in1_arr[gi]        = '0;
         assign in2_arr[gi]        = '0;
         assign cmd_arr[gi]        = '0;
         assign resp_ready_pad[gi] = 1'b0;
      end
   end

   logic [ARB_IDX_W-1:0] grant;
   logic                 any_valid;

   alu_share_arbiter_rr_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_picker (
      .valid_i      (req_valid),
      .last_grant_i (last_grant_q),
      .grant_o      (grant),
      .any_valid_o  (any_valid)
   );

   logic [31:0] alu_out;

   alu u_alu (
      .in1_i     (in1_arr[grant]),
      .in2_i     (in2_arr[grant]),
      .cmd_i     (alu_cmd_e'(cmd_arr[grant])),
      .alu_out_o (alu_out)
   );

   logic resp_hs;
   logic can_accept;
   logic accept;

   // The buffer can take a new result when empty or when it drains this
   // cycle; that same-cycle drain-and-refill sustains one op per cycle.
   assign resp_hs    = (state_q == ARB_FULL) && resp_ready_pad[owner_q];
   assign can_accept = (state_q == ARB_EMPTY) || resp_ready_pad[owner_q];
   assign accept     = can_accept && any_valid;

   assign req_ready  = accept ? (NUM_REQ'(1) << grant) : '0;
   assign resp_valid = (state_q == ARB_FULL) ? (NUM_REQ'(1) << owner_q) : '0;
   assign resp_data  = resp_data_q;
   assign ops_done   = ops_done_q;
   assign busy       = (state_q == ARB_FULL);

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      resp_data_d  = resp_data_q;
      ops_done_d   = ops_done_q + CNT_W'(resp_hs);
      if (accept) begin
         state_d      = ARB_FULL;
         owner_d      = grant;
         last_grant_d = grant;
         resp_data_d  = alu_out;
      end else if (resp_hs) begin
         state_d      = ARB_EMPTY;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ARB_EMPTY;
         owner_q      <= '0;
         last_grant_q <= ARB_IDX_W'(NUM_REQ - 1);
         resp_data_q  <= '0;
         ops_done_q   <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         resp_data_q  <= resp_data_d;
         ops_done_q   <= ops_done_d;
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
// Bench for alu_share_arbiter: directed scenarios with literal expectations
// plus randomized traffic, all outputs compared every cycle against a
// queue-based behavioural model.
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;

   localparam int NUM_REQ = 2;
   localparam int CNT_W   = 16;

   localparam logic [2:0] C_ADD = 3'd0, C_SUB = 3'd1, C_AND = 3'd2, C_OR  = 3'd3,
                          C_XOR = 3'd4, C_SLL = 3'd5, C_SRL = 3'd6, C_SRA = 3'd7;

   logic                  clk = 1'b0;
   logic                  reset_n;
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ*32-1:0] req_in1;
   logic [NUM_REQ*32-1:0] req_in2;
   logic [NUM_REQ*3-1:0]  req_cmd;
   logic [NUM_REQ-1:0]    resp_valid;
   logic [NUM_REQ-1:0]    resp_ready;
   logic [31:0]           resp_data;
   logic [CNT_W-1:0]      ops_done;
   logic                  busy;

   alu_share_arbiter #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_in1    (req_in1),
      .req_in2    (req_in2),
      .req_cmd    (req_cmd),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .ops_done   (ops_done),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Requester-side stimulus state
   logic [31:0] in1_r [NUM_REQ];
   logic [31:0] in2_r [NUM_REQ];
   logic [2:0]  cmd_r [NUM_REQ];
   bit          pend  [NUM_REQ];

   // Behavioural model: the result buffer is a queue holding at most one
   // {owner, data} entry; resp_data is the last captured result.
   typedef struct {
      int          owner;
      logic [31:0] data;
   } rsp_t;
   rsp_t             buf_m[$];
   int               m_last;
   logic [31:0]      m_data;
   logic [CNT_W-1:0] m_cnt;
   logic [NUM_REQ-1:0] m_gnt;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic logic [31:0] alu_ref(logic [31:0] a, logic [31:0] b, logic [2:0] c);
      int sh;
      sh = int'(b[4:0]);
      case (c)
         C_ADD:   return a + b;
         C_SUB:   return a - b;
         C_AND:   return a & b;
         C_OR:    return a | b;
         C_XOR:   return a ^ b;
         C_SLL:   return a << sh;
         C_SRL:   return a >> sh;
         default: begin
            // arithmetic shift: fill vacated high bits with the sign
            logic [31:0] r;
            r = a >> sh;
            if (a[31] && sh > 0) r = r | ~(32'hFFFF_FFFF >> sh);
            return r;
         end
      endcase
   endfunction

   task automatic model_reset();
      buf_m.delete();
      m_last = NUM_REQ - 1;
      m_data = '0;
      m_cnt  = '0;
      m_gnt  = '0;
      for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
   endtask

   task automatic drive(input logic [NUM_REQ-1:0] v, input logic [NUM_REQ-1:0] rr);
      req_valid  = v;
      resp_ready = rr;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_in1[32*i +: 32] = in1_r[i];
         req_in2[32*i +: 32] = in2_r[i];
         req_cmd[3*i +: 3]   = cmd_r[i];
      end
   endtask

   task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
      in1_r[i] = a;
      in2_r[i] = b;
      cmd_r[i] = c;
   endtask

   // Called in the low phase with inputs applied: compare every output
   // against the model, advance the model, then move to the next low phase.
   task automatic step();
      logic [NUM_REQ-1:0] e_rr, e_rv;
      bit   has, hs, can, found;
      int   g, own;
      #1;
      has = (buf_m.size() > 0);
      own = has ? buf_m[0].owner : 0;
      hs  = has && resp_ready[own];
      can = !has || hs;
      found = 1'b0;
      g = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         int idx;
         idx = (m_last + k) % NUM_REQ;
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            g = idx;
         end
      end
      e_rr = '0;
      if (can && found) e_rr[g] = 1'b1;
      e_rv = '0;
      if (has) e_rv[own] = 1'b1;
      check("req_ready",  32'(req_ready),  32'(e_rr));
      check("resp_valid", 32'(resp_valid), 32'(e_rv));
      check("busy",       32'(busy),       32'(has));
      check("resp_data",  resp_data,       m_data);
      check("ops_done",   32'(ops_done),   32'(m_cnt));
      if (hs) begin
         buf_m.delete(0);
         m_cnt = m_cnt + 1'b1;
      end
      m_gnt = e_rr;
      if (can && found) begin
         rsp_t e;
         e.owner = g;
         e.data  = alu_ref(in1_r[g], in2_r[g], cmd_r[g]);
         buf_m.push_back(e);
         m_last = g;
         m_data = e.data;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      reset_n = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) set_op(i, '0, '0, C_ADD);
      drive('0, '0);
      model_reset();
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_resp_valid", 32'(resp_valid), 32'h0);
      check("rst_resp_data",  resp_data,       32'h0);
      check("rst_ops_done",   32'(ops_done),   32'h0);
      check("rst_busy",       32'(busy),       32'h0);
      reset_n = 1'b1;

      // T1: single add from requester 0
      set_op(0, 32'h500, 32'h100, C_ADD);
      drive(2'b01, 2'b01);
      #1 check("t1_req_ready", 32'(req_ready), 32'h1);
      step();
      $display("txn T1 add(0x500,0x100) resp_valid=%b resp_data=0x%08h", resp_valid, resp_data);
      check("t1_resp_valid", 32'(resp_valid), 32'h1);
      check("t1_resp_data",  resp_data,       32'h600);
      drive(2'b00, 2'b01);
      step();
      check("t1_ops_done", 32'(ops_done), 32'h1);

      // T2: both requesters every cycle; last grant was 0 so 1 goes first
      set_op(0, 32'd10, 32'd3, C_SUB);
      set_op(1, 32'hF0, 32'hFF, C_XOR);
      drive(2'b11, 2'b11);
      for (int c = 0; c < 4; c++) begin
         step();
         $display("txn T2 cycle %0d resp_valid=%b resp_data=0x%08h", c, resp_valid, resp_data);
         check("t2_resp_data",  resp_data,       (c % 2 == 0) ? 32'h0F : 32'd7);
         check("t2_resp_valid", 32'(resp_valid), (c % 2 == 0) ? 32'h2  : 32'h1);
      end
      drive(2'b00, 2'b11);
      step();
      check("t2_ops_done", 32'(ops_done), 32'd5);

      // T3: owner 1 stalls, requester 0 must wait, then drain-and-refill
      set_op(1, 32'd1, 32'd31, C_SLL);
      drive(2'b10, 2'b00);
      #1 check("t3_req_ready1", 32'(req_ready), 32'h2);
      step();
      set_op(0, 32'd1, 32'd2, C_ADD);
      drive(2'b01, 2'b00);
      for (int c = 0; c < 5; c++) begin
         #1;
         check("t3_stall_req_ready", 32'(req_ready), 32'h0);
         check("t3_hold_data",       resp_data,      32'h8000_0000);
         step();
      end
      drive(2'b01, 2'b10);
      #1 check("t3_refill_req_ready", 32'(req_ready), 32'h1);
      step();
      $display("txn T3 refill resp_valid=%b resp_data=0x%08h", resp_valid, resp_data);
      check("t3_refill_data", resp_data, 32'd3);
      drive(2'b00, 2'b01);
      step();

      // T4: back-to-back arithmetic then logical right shift
      set_op(0, 32'h8000_0000, 32'd4, C_SRA);
      drive(2'b01, 2'b01);
      step();
      check("t4_sra", resp_data, 32'hF800_0000);
      set_op(0, 32'h8000_0000, 32'd4, C_SRL);
      drive(2'b01, 2'b01);
      step();
      check("t4_srl", resp_data, 32'h0800_0000);
      $display("txn T4 srl resp_data=0x%08h", resp_data);
      drive(2'b00, 2'b01);
      step();

      // T5: asynchronous reset while FULL
      set_op(0, 32'h1000, 32'h234, C_ADD);
      drive(2'b01, 2'b00);
      step();
      check("t5_full_data", resp_data, 32'h1234);
      check("t5_full_busy", 32'(busy), 32'h1);
      #2 reset_n = 1'b0;
      #1;
      check("t5_arst_resp_valid", 32'(resp_valid), 32'h0);
      check("t5_arst_busy",       32'(busy),       32'h0);
      check("t5_arst_resp_data",  resp_data,       32'h0);
      model_reset();
      drive(2'b00, 2'b00);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      set_op(0, 32'd5, 32'd6, C_AND);
      set_op(1, 32'd5, 32'd6, C_OR);
      drive(2'b11, 2'b11);
      #1 check("t5_prio_req_ready", 32'(req_ready), 32'h1);
      step();
      $display("txn T5 post-reset grant resp_valid=%b", resp_valid);
      drive(2'b00, 2'b11);
      step();

      // Randomized traffic; a waiting requester holds valid and operands.
      for (int c = 0; c < 3000; c++) begin
         logic [NUM_REQ-1:0] v, rr;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!pend[i] && $urandom_range(0, 99) < 60) begin
               pend[i] = 1'b1;
               set_op(i, $urandom, $urandom, 3'($urandom_range(0, 7)));
            end
            v[i]  = pend[i];
            rr[i] = ($urandom_range(0, 99) < 70);
         end
         drive(v, rr);
         step();
         for (int i = 0; i < NUM_REQ; i++) if (m_gnt[i]) pend[i] = 1'b0;
      end
      drive(2'b00, 2'b11);
      step();
      for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;

      // Counter wrap: stream handshakes until the count reaches all-ones.
      set_op(0, 32'd7, 32'd9, C_ADD);
      drive(2'b01, 2'b11);
      for (int c = 0; c < 70000 && m_cnt != {CNT_W{1'b1}}; c++) step();
      check("wrap_at_max", 32'(ops_done), 32'h0000_FFFF);
      drive(2'b00, 2'b11);
      step();
      check("wrap_to_zero", 32'(ops_done), 32'h0);
      $display("txn WRAP ops_done=0x%04h", ops_done);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
